// File: rtl/dsec_pkg.sv
// dsec_pkg: shared widths, limits and packer state encoding for the dsec datapath
package dsec_pkg;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 7;
   localparam int ACC_W  = 128;
   localparam int FILL_W = 8;
   localparam logic [CNT_W-1:0]  MAX_VALID_BITS = 7'd64;
   localparam logic [FILL_W-1:0] WORD_FILL      = 8'd64;
   localparam logic [FILL_W-1:0] ACC_FILL       = 8'd128;
   typedef enum logic [1:0] {PACK, FLUSH, WAIT_LAST, DONE} pack_state_t;
endpackage

// File: rtl/packer_out_reg.sv
// packer_out_reg: single-entry valid/ready output slot holding a packed word and its framing
module packer_out_reg
   import dsec_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   input  logic [CNT_W-1:0]  i_pad,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic [CNT_W-1:0]  o_pad,
   output logic              o_slot_free
);
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic [CNT_W-1:0]  r_pad;

   // Load a new word, or retire the held one when downstream takes it; framing clears once consumed
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_pad   <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
         r_pad   <= i_pad;
      end else if (i_ready) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_pad   <= '0;
      end
   end

   assign o_valid     = r_valid;
   assign o_data      = r_data;
   assign o_last      = r_last;
   assign o_pad       = r_pad;
   assign o_slot_free = !r_valid || i_ready;
endmodule

// File: rtl/var_len_packer.sv
// var_len_packer: packs 0..64-bit right-justified codewords MSB-first into dense 64-bit words
module var_len_packer
   import dsec_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic [CNT_W-1:0]  valid_bits,
   input  logic              msg_fin,
   output logic              stall,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [CNT_W-1:0]  pad_bits,
   output logic              done,
   output logic              error
);
   pack_state_t       r_state;
   logic [ACC_W-1:0]  r_acc;
   logic [FILL_W-1:0] r_fill;
   logic              r_done;
   logic              r_error;
   logic              w_slot_free;
   logic              w_drain;
   logic              w_accept;
   logic              w_legal;
   logic              w_fin_now;
   logic              w_last_drain;
   logic              w_pad_emit;
   logic              w_load;
   logic [FILL_W-1:0] w_fill_pd;
   logic [FILL_W-1:0] w_nbits;
   logic [ACC_W-1:0]  w_acc_pd;
   logic [ACC_W-1:0]  w_ins;
   logic [DATA_W-1:0] w_mask;
   logic [CNT_W-1:0]  w_pad;

   // Drain decision from the registered fill, then append the beat behind the post-drain contents
   always_comb begin
      w_drain      = (r_fill >= WORD_FILL) && w_slot_free;
      w_fill_pd    = w_drain ? r_fill - WORD_FILL : r_fill;
      w_acc_pd     = w_drain ? {r_acc[DATA_W-1:0], {DATA_W{1'b0}}} : r_acc;
      stall        = (w_fill_pd > WORD_FILL) || (r_state != PACK);
      w_accept     = data_valid && !stall;
      w_legal      = valid_bits <= MAX_VALID_BITS;
      w_nbits      = (w_accept && w_legal) ? {1'b0, valid_bits} : '0;
      w_mask       = ~({DATA_W{1'b1}} << w_nbits);
      w_ins        = {{DATA_W{1'b0}}, data_in & w_mask} << (ACC_FILL - w_fill_pd - w_nbits);
      w_fin_now    = w_accept && msg_fin;
      w_last_drain = w_drain && (w_fill_pd == '0) && ((r_state == FLUSH) || (w_fin_now && w_nbits == '0));
      w_pad_emit   = (r_state == FLUSH) && (r_fill != '0) && (r_fill < WORD_FILL) && w_slot_free;
      w_load       = w_drain || w_pad_emit;
      w_pad        = w_pad_emit ? CNT_W'(WORD_FILL - r_fill) : '0;
   end

   // Accumulator, fill counter, sticky error and message FSM with a registered done pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= PACK;
         r_acc   <= '0;
         r_fill  <= '0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_acc   <= w_pad_emit ? '0 : (w_acc_pd | w_ins);
         r_fill  <= w_pad_emit ? '0 : w_fill_pd + w_nbits;
         r_error <= r_error || (w_accept && !w_legal);
         r_done  <= 1'b0;
         case (r_state)
            PACK:      if (w_fin_now) r_state <= w_last_drain ? WAIT_LAST : FLUSH;
            FLUSH:     if (w_last_drain || w_pad_emit) r_state <= WAIT_LAST;
                       else if (r_fill == '0 && !out_valid) begin
                          r_state <= DONE;
                          r_done  <= 1'b1;
                       end
            WAIT_LAST: if (out_valid && out_ready) begin
                          r_state <= DONE;
                          r_done  <= 1'b1;
                       end
            DONE:      r_state <= PACK;
         endcase
      end
   end

   packer_out_reg u_out (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_data      (r_acc[ACC_W-1:DATA_W]),
      .i_last      (w_last_drain || w_pad_emit),
      .i_pad       (w_pad),
      .i_ready     (out_ready),
      .o_valid     (out_valid),
      .o_data      (data_out),
      .o_last      (out_last),
      .o_pad       (pad_bits),
      .o_slot_free (w_slot_free)
   );

   assign done  = r_done;
   assign error = r_error;
endmodule

// File: tb/tb_var_len_packer.sv
// tb_var_len_packer: directed scenario tasks with hand-computed expectations for var_len_packer
module tb_var_len_packer;
   import dsec_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic [CNT_W-1:0]  valid_bits;
   logic              msg_fin;
   logic              stall;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [CNT_W-1:0]  pad_bits;
   logic              done;
   logic              error;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   var_len_packer dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .valid_bits (valid_bits),
      .msg_fin    (msg_fin),
      .stall      (stall),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .pad_bits   (pad_bits),
      .done       (done),
      .error      (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] d, input logic [6:0] n, input logic f, input logic v);
      data_in = d;
      valid_bits = n;
      msg_fin = f;
      data_valid = v;
   endtask

   task automatic idle();
      drive(64'h0, 7'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      out_ready = 1'b1;
      idle();
      tick();
      tick();
      n_vec++; if (data_out !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_out); end
      n_vec++; if ({out_valid, out_last, pad_bits, done, error} !== 11'h0) begin n_err++; $display("FAIL reset_flags got %b want 0", {out_valid, out_last, pad_bits, done, error}); end
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
      rst = 1'b1;
   endtask

   task automatic test_four_beats();
      logic [15:0] w [4];
      w = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      for (int i = 0; i < 4; i++) begin
         drive({48'h0, w[i]}, 7'd16, 1'b0, 1'b1);
         #1;
         n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL four_stall beat %0d got %b want 0", i, stall); end
         tick();
      end
      idle();
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL four_valid got %b want 1", out_valid); end
      n_vec++; if (data_out !== 64'hAAAA_BBBB_CCCC_DDDD) begin n_err++; $display("FAIL four_data got %h want aaaabbbbccccdddd", data_out); end
      n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL four_last got %b want 0", out_last); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL four_pop got %b want 0", out_valid); end
   endtask

   task automatic test_pad_flush();
      drive(64'h12_3456_7890, 7'd40, 1'b0, 1'b1);
      tick();
      drive(64'hAB_CDEF_0123, 7'd40, 1'b1, 1'b1);
      #1;
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL pad_stall0 got %b want 0", stall); end
      tick();
      idle();
      tick();
      n_vec++; if (out_valid !== 1'b1 || data_out !== 64'h1234_5678_90AB_CDEF) begin n_err++; $display("FAIL pad_word0 got v=%b %h want v=1 1234567890abcdef", out_valid, data_out); end
      n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL pad_last0 got %b want 0", out_last); end
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL pad_flush_stall got %b want 1", stall); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || data_out !== 64'h0123_0000_0000_0000) begin n_err++; $display("FAIL pad_word1 got v=%b %h want v=1 0123000000000000", out_valid, data_out); end
      n_vec++; if (out_last !== 1'b1 || pad_bits !== 7'd48) begin n_err++; $display("FAIL pad_frame got last=%b pad=%0d want last=1 pad=48", out_last, pad_bits); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL pad_done_early got %b want 0", done); end
      tick();
      n_vec++; if (done !== 1'b1 || out_last !== 1'b0 || pad_bits !== 7'd0) begin n_err++; $display("FAIL pad_done got done=%b last=%b pad=%0d want 1 0 0", done, out_last, pad_bits); end
      tick();
      n_vec++; if (done !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL pad_release got done=%b stall=%b want 0 0", done, stall); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] beats [6];
      int sent = 0;
      int got = 0;
      logic took;
      for (int i = 0; i < 6; i++) beats[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      for (int c = 0; c < 40 && got < 6; c++) begin
         out_ready = (c >= 5);
         if (sent < 6) drive(beats[sent], 7'd64, 1'b0, 1'b1);
         else idle();
         #1;
         if (c == 2) begin n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL bp_stall_c2 got %b want 0", stall); end end
         if (c == 3) begin n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL bp_stall_c3 got %b want 1", stall); end end
         if (c == 4) begin n_vec++; if (out_valid !== 1'b1 || data_out !== beats[0]) begin n_err++; $display("FAIL bp_hold got v=%b %h want v=1 %h", out_valid, data_out, beats[0]); end end
         if (out_valid && out_ready) begin
            n_vec++; if (data_out !== beats[got]) begin n_err++; $display("FAIL bp_word%0d got %h want %h", got, data_out, beats[got]); end
            got++;
         end
         took = data_valid && !stall;
         tick();
         if (took) sent++;
      end
      idle();
      n_vec++; if (got !== 6 || sent !== 6) begin n_err++; $display("FAIL bp_count got words=%0d beats=%0d want 6 6", got, sent); end
   endtask

   task automatic test_error();
      logic [7:0] b [8];
      b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      out_ready = 1'b1;
      drive({56'h0, b[0]}, 7'd8, 1'b0, 1'b1);
      tick();
      drive(64'hFFFF_FFFF_FFFF_FFFF, 7'd65, 1'b0, 1'b1);
      tick();
      n_vec++; if (error !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", error); end
      for (int i = 1; i < 8; i++) begin
         drive({56'h0, b[i]}, 7'd8, 1'b0, 1'b1);
         tick();
      end
      idle();
      tick();
      n_vec++; if (out_valid !== 1'b1 || data_out !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL err_word got v=%b %h want v=1 1122334455667788", out_valid, data_out); end
      tick();
      n_vec++; if (error !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL err_sticky got err=%b v=%b want 1 0", error, out_valid); end
      rst = 1'b0;
      tick();
      n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", error); end
      rst = 1'b1;
   endtask

   task automatic test_empty_exact();
      drive(64'h0, 7'd0, 1'b1, 1'b1);
      tick();
      idle();
      #1;
      n_vec++; if (stall !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL empty_flush got stall=%b v=%b done=%b want 1 0 0", stall, out_valid, done); end
      tick();
      n_vec++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL empty_done got done=%b v=%b want 1 0", done, out_valid); end
      tick();
      n_vec++; if (done !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL empty_release got done=%b stall=%b want 0 0", done, stall); end
      drive(64'hDEAD_BEEF_CAFE_F00D, 7'd64, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      n_vec++; if (out_valid !== 1'b1 || data_out !== 64'hDEAD_BEEF_CAFE_F00D) begin n_err++; $display("FAIL exact_word got v=%b %h want v=1 deadbeefcafef00d", out_valid, data_out); end
      n_vec++; if (out_last !== 1'b1 || pad_bits !== 7'd0) begin n_err++; $display("FAIL exact_frame got last=%b pad=%0d want 1 0", out_last, pad_bits); end
      tick();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL exact_done got %b want 1", done); end
      tick();
   endtask

   task automatic test_reset_in_flush();
      out_ready = 1'b0;
      drive(64'h12_3456_7890, 7'd40, 1'b1, 1'b1);
      tick();
      idle();
      rst = 1'b0;
      tick();
      n_vec++; if (data_out !== 64'h0) begin n_err++; $display("FAIL rf_data got %h want 0", data_out); end
      n_vec++; if ({out_valid, out_last, pad_bits, done, error, stall} !== 12'h0) begin n_err++; $display("FAIL rf_flags got %b want 0", {out_valid, out_last, pad_bits, done, error, stall}); end
      rst = 1'b1;
      out_ready = 1'b1;
      drive(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      n_vec++; if (out_valid !== 1'b1 || data_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL rf_word got v=%b %h want v=1 ffffffffffffffff", out_valid, data_out); end
      n_vec++; if (out_last !== 1'b0 || pad_bits !== 7'd0) begin n_err++; $display("FAIL rf_frame got last=%b pad=%0d want 0 0", out_last, pad_bits); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_alone got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_four_beats();
      test_pad_flush();
      test_back_to_back();
      test_error();
      test_empty_exact();
      test_reset_in_flush();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
